fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of decode and directly driving the branch predictor's access port. It holds the architectural fetch PC and presents it to the predictor. It issues one instruction-cache request at a time, then pushes each returned instruction, tagged with its PC and its prediction, into a small in-order queue. Decode pops from that queue. Backend flushes redirect the PC and discard all in-flight and queued work.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC register, single-outstanding I$ requester
// and in-order fetch queue feeding decode.
module fetch_stage #(
    parameter int                 PC_BITS     = 32,
    parameter int                 INSTR_BITS  = 32,
    parameter logic [PC_BITS-1:0] RESET_PC    = '0,
    parameter int                 QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  must_flush,
    input  logic [PC_BITS-1:0]    correct_pc,
    output logic [PC_BITS-1:0]    pred_pc,
    input  logic [PC_BITS-1:0]    pred_next_pc,
    input  logic                  pred_taken,
    output logic                  icache_req,
    output logic [PC_BITS-1:0]    icache_addr,
    input  logic                  icache_valid,
    input  logic [INSTR_BITS-1:0] icache_data,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [INSTR_BITS-1:0] instr_o,
    output logic [PC_BITS-1:0]    pc_o,
    output logic                  taken_o,
    output logic [PC_BITS-1:0]    next_pc_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    typedef struct packed {
        logic [INSTR_BITS-1:0] instr;
        logic [PC_BITS-1:0]    pc;
        logic                  taken;
        logic [PC_BITS-1:0]    npc;
    } entry_t;

    state_t             state_q;
    state_t             state_d;
    logic [PC_BITS-1:0] fetch_pc;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    entry_t             mem [QUEUE_DEPTH];
    entry_t             head_e;
    logic               can_req;
    logic               push;
    logic               pop;

    assign pred_pc     = fetch_pc;
    assign icache_addr = fetch_pc;
    assign valid_o     = (count != '0);
    assign head_e      = mem[head];

    // A request needs a free slot so the response always fits.
    assign can_req = rst_n && (state_q == S_REQ) && !must_flush
                     && (count < FULL);
    assign push    = (state_q == S_WAIT) && icache_valid && !must_flush;
    assign pop     = valid_o && ready_i;

    // Control state and fetch PC; a flush always wins the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (must_flush)
                fetch_pc <= correct_pc;
            else if (push)
                fetch_pc <= pred_next_pc;
        end
    end

    // Next state: a flush with a response still owed parks in DROP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (can_req)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (must_flush)
                    state_d = icache_valid ? S_REQ : S_DROP;
                else if (icache_valid)
                    state_d = S_REQ;
            end
            S_DROP: begin
                if (icache_valid)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Request strobe is only raised from REQ with space available.
    always_comb begin
        icache_req = can_req;
    end

    // Queue pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (must_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage: fetched word tagged with PC and prediction.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= '{instr: icache_data, pc: fetch_pc,
                           taken: pred_taken, npc: pred_next_pc};
    end

    // Head fields read as zero while the queue is empty.
    always_comb begin
        instr_o   = '0;
        pc_o      = '0;
        taken_o   = 1'b0;
        next_pc_o = '0;
        if (valid_o) begin
            instr_o   = head_e.instr;
            pc_o      = head_e.pc;
            taken_o   = head_e.taken;
            next_pc_o = head_e.npc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a
// cycle-stepped I$ responder and a simple predictor model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        must_flush = 1'b0;
    logic [31:0] correct_pc = '0;
    logic [31:0] pred_pc;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid = 1'b0;
    logic [31:0] icache_data = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        taken_o;
    logic [31:0] next_pc_o;

    int errors = 0;
    int checks = 0;

    logic        tk_en = 1'b0;
    logic [31:0] tk_pc = '0;
    logic [31:0] tk_tgt = '0;

    int          lat = 1;
    int          wait_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          cyc = 0;

    logic [31:0] req_log [$];
    int          req_cyc [$];
    logic [31:0] pop_pc [$];
    logic [31:0] pop_instr [$];
    logic        pop_tk [$];
    logic [31:0] pop_npc [$];

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .must_flush   (must_flush),
        .correct_pc   (correct_pc),
        .pred_pc      (pred_pc),
        .pred_next_pc (pred_next_pc),
        .pred_taken   (pred_taken),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_valid (icache_valid),
        .icache_data  (icache_data),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .taken_o      (taken_o),
        .next_pc_o    (next_pc_o)
    );

    always #5 clk = ~clk;

    assign pred_taken   = tk_en && (pred_pc == tk_pc);
    assign pred_next_pc = pred_taken ? tk_tgt : pred_pc + 32'd4;

    always @(negedge clk) begin
        if (rst_n && dut.push && dut.count == 3'd4) begin
            errors++;
            $display("FAIL queue_overflow: push with count=%0d, want count<4",
                     dut.count);
        end
    end

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        pop_pc.delete();
        pop_instr.delete();
        pop_tk.delete();
        pop_npc.delete();
    endtask

    // One clock cycle, entered and left just after the rising edge.
    task automatic cycle();
        logic        req_seen;
        logic [31:0] req_a;
        icache_valid = (wait_cnt == 1);
        icache_data  = icache_valid ? ~pend_addr : '0;
        @(negedge clk);
        req_seen = icache_req;
        req_a    = icache_addr;
        if (req_seen) begin
            req_log.push_back(req_a);
            req_cyc.push_back(cyc);
        end
        if (valid_o && ready_i) begin
            pop_pc.push_back(pc_o);
            pop_instr.push_back(instr_o);
            pop_tk.push_back(taken_o);
            pop_npc.push_back(next_pc_o);
        end
        @(posedge clk);
        #1;
        if (wait_cnt == 1)
            wait_cnt = 0;
        else if (wait_cnt > 1)
            wait_cnt--;
        if (req_seen && rst_n) begin
            wait_cnt  = lat;
            pend_addr = req_a;
        end
        icache_valid = (wait_cnt == 1);
        icache_data  = icache_valid ? ~pend_addr : '0;
        cyc++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        must_flush = 1'b0;
        correct_pc = '0;
        ready_i = 1'b0;
        tk_en = 1'b0;
        wait_cnt = 0;
        icache_valid = 1'b0;
        icache_data = '0;
        lat = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        cyc = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", icache_req); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        checks++; if (pred_pc !== 32'h0) begin errors++; $display("FAIL rst_pred_pc: got %h want 0", pred_pc); end
        checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", icache_addr); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_o); end
        checks++; if (taken_o !== 1'b0 || next_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pred_fields: got %b/%h want 0/0", taken_o, next_pc_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        clear_logs();
    endtask

    task automatic test_fetch_seq();
        ready_i = 1'b1;
        repeat (7) cycle();
        checks++;
        if (req_log.size() < 3) begin
            errors++; $display("FAIL seq_req_count: got %0d want >=3", req_log.size());
        end else begin
            checks++; if (req_log[0] !== 32'h0 || req_cyc[0] != 0) begin errors++; $display("FAIL seq_req0: got %h@%0d want 0@0", req_log[0], req_cyc[0]); end
            checks++; if (req_log[1] !== 32'h4 || req_cyc[1] != 2) begin errors++; $display("FAIL seq_req1: got %h@%0d want 4@2", req_log[1], req_cyc[1]); end
            checks++; if (req_log[2] !== 32'h8 || req_cyc[2] != 4) begin errors++; $display("FAIL seq_req2: got %h@%0d want 8@4", req_log[2], req_cyc[2]); end
        end
        checks++;
        if (pop_pc.size() != 3) begin
            errors++; $display("FAIL seq_pop_count: got %0d want 3", pop_pc.size());
        end else begin
            checks++; if (pop_pc[0] !== 32'h0 || pop_instr[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL seq_pop0: got %h/%h want 0/ffffffff", pop_pc[0], pop_instr[0]); end
            checks++; if (pop_pc[1] !== 32'h4 || pop_instr[1] !== 32'hFFFF_FFFB) begin errors++; $display("FAIL seq_pop1: got %h/%h want 4/fffffffb", pop_pc[1], pop_instr[1]); end
            checks++; if (pop_pc[2] !== 32'h8 || pop_npc[2] !== 32'hC) begin errors++; $display("FAIL seq_pop2: got %h/%h want 8/c", pop_pc[2], pop_npc[2]); end
            checks++; if (pop_tk[0] !== 1'b0 || pop_tk[1] !== 1'b0 || pop_tk[2] !== 1'b0) begin errors++; $display("FAIL seq_taken: got %b%b%b want 000", pop_tk[0], pop_tk[1], pop_tk[2]); end
        end
    endtask

    task automatic test_taken();
        apply_reset();
        tk_en = 1'b1;
        tk_pc = 32'h8;
        tk_tgt = 32'h100;
        ready_i = 1'b1;
        repeat (8) cycle();
        checks++;
        if (req_log.size() != 4 || pop_pc.size() != 3) begin
            errors++; $display("FAIL tk_counts: got req=%0d pop=%0d want 4/3", req_log.size(), pop_pc.size());
        end else begin
            checks++; if (req_log[3] !== 32'h100 || req_cyc[3] != 6) begin errors++; $display("FAIL tk_redirect_req: got %h@%0d want 100@6", req_log[3], req_cyc[3]); end
            checks++; if (pop_pc[2] !== 32'h8 || pop_tk[2] !== 1'b1) begin errors++; $display("FAIL tk_entry: got pc=%h tk=%b want 8/1", pop_pc[2], pop_tk[2]); end
            checks++; if (pop_npc[2] !== 32'h100 || pop_instr[2] !== 32'hFFFF_FFF7) begin errors++; $display("FAIL tk_entry_npc: got %h/%h want 100/fffffff7", pop_npc[2], pop_instr[2]); end
            checks++; if (pop_tk[1] !== 1'b0 || pop_npc[1] !== 32'h8) begin errors++; $display("FAIL tk_prev_entry: got %b/%h want 0/8", pop_tk[1], pop_npc[1]); end
        end
    endtask

    task automatic test_queue_full();
        apply_reset();
        repeat (12) cycle();
        checks++; if (req_log.size() != 4) begin errors++; $display("FAIL full_req_count: got %0d want 4", req_log.size()); end
        checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", dut.count); end
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || icache_req !== 1'b0) begin errors++; $display("FAIL full_head: got v=%b pc=%h req=%b want 1/0/0", valid_o, pc_o, icache_req); end
        ready_i = 1'b1;
        cycle();
        ready_i = 1'b0;
        repeat (3) cycle();
        checks++; if (pop_pc.size() != 1 || pop_pc[0] !== 32'h0) begin errors++; $display("FAIL full_pop: got n=%0d want one pop of pc 0", pop_pc.size()); end
        checks++;
        if (req_log.size() != 5) begin
            errors++; $display("FAIL full_refill_count: got %0d want 5", req_log.size());
        end else begin
            checks++; if (req_log[4] !== 32'h10 || req_cyc[4] != 13) begin errors++; $display("FAIL full_refill_req: got %h@%0d want 10@13", req_log[4], req_cyc[4]); end
        end
        checks++; if (pc_o !== 32'h4 || next_pc_o !== 32'h8 || dut.count !== 3'd4) begin errors++; $display("FAIL full_after: got pc=%h npc=%h cnt=%0d want 4/8/4", pc_o, next_pc_o, dut.count); end
    endtask

    task automatic test_flush_late();
        apply_reset();
        lat = 3;
        ready_i = 1'b1;
        cycle();
        must_flush = 1'b1;
        correct_pc = 32'h200;
        cycle();
        must_flush = 1'b0;
        checks++; if (valid_o !== 1'b0 || pred_pc !== 32'h200) begin errors++; $display("FAIL fl_next: got v=%b pc=%h want 0/200", valid_o, pred_pc); end
        checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL fl_drop_req: got %b want 0", icache_req); end
        repeat (4) cycle();
        checks++;
        if (req_log.size() != 2) begin
            errors++; $display("FAIL fl_req_count: got %0d want 2", req_log.size());
        end else begin
            checks++; if (req_log[1] !== 32'h200 || req_cyc[1] != 4) begin errors++; $display("FAIL fl_req: got %h@%0d want 200@4", req_log[1], req_cyc[1]); end
        end
        checks++; if (pop_pc.size() != 0 || valid_o !== 1'b0) begin errors++; $display("FAIL fl_no_push: got pops=%0d v=%b want 0/0", pop_pc.size(), valid_o); end
    endtask

    task automatic test_flush_pop();
        apply_reset();
        repeat (5) cycle();
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL fp_setup: got count=%0d want 2", dut.count); end
        must_flush = 1'b1;
        correct_pc = 32'h300;
        ready_i = 1'b1;
        cycle();
        must_flush = 1'b0;
        ready_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || dut.count !== 3'd0) begin errors++; $display("FAIL fp_empty: got v=%b cnt=%0d want 0/0", valid_o, dut.count); end
        checks++; if (pred_pc !== 32'h300) begin errors++; $display("FAIL fp_pc: got %h want 300", pred_pc); end
        cycle();
        checks++;
        if (req_log.size() != 4) begin
            errors++; $display("FAIL fp_req_count: got %0d want 4", req_log.size());
        end else begin
            checks++; if (req_log[3] !== 32'h300 || req_cyc[3] != 6) begin errors++; $display("FAIL fp_req: got %h@%0d want 300@6", req_log[3], req_cyc[3]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        cycle();
        cycle();
        lat = 3;
        cycle();
        rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL rw_clear: got v=%b i=%h pc=%h want 0/0/0", valid_o, instr_o, pc_o); end
        checks++; if (pred_pc !== 32'h0 || icache_req !== 1'b0) begin errors++; $display("FAIL rw_pc: got %h req=%b want 0/0", pred_pc, icache_req); end
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_logs();
        cycle();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rw_ignored: got v=%b want 0", valid_o); end
        checks++;
        if (req_log.size() != 1) begin
            errors++; $display("FAIL rw_req_count: got %0d want 1", req_log.size());
        end else begin
            checks++; if (req_log[0] !== 32'h0 || req_cyc[0] != 5) begin errors++; $display("FAIL rw_req: got %h@%0d want 0@5", req_log[0], req_cyc[0]); end
        end
        repeat (3) cycle();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rw_fresh: got v=%b pc=%h i=%h want 1/0/ffffffff", valid_o, pc_o, instr_o); end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_taken();
        test_queue_full();
        test_flush_late();
        test_flush_pop();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
